// File: rtl/bin_decode_ctrl.sv
// bin_decode_ctrl: sequences the arithmetic decoder one bin group at a time and manages byte refills
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   cmd_*             bin-group command (pState, bypass flag, bin count) with valid/ready
//   dec_pstate/bypass latched command fields driven to the Decoder
//   dec_n_bin         bins decoded this step minus 1
//   dec_step          Decoder consumes/advances this cycle
//   dec_bin           combinational bins from the Decoder
//   dec_renorm        regular bin needed renormalisation
//   dec_num_bits      renormalisation shift for a regular bin
//   byte_request      byte fetch request, held until byte_ready
//   byte_ready        byte available from the reader
//   upd_en/upd_sel    add the fetched byte into m_value path RE/EP0/EP1/EP2
//   bin_valid         bins_out/bins_cnt valid (one cycle after the step)
//   bins_out/bins_cnt decoded bins (LSB first, unused bits 0) and count minus 1
//   cmd_done          one-cycle pulse when the command completes
module bin_decode_ctrl #(
    parameter int BIN_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_pstate,
    input  logic                 cmd_bypass,
    input  logic [6:0]           cmd_num_bins,
    output logic [7:0]           dec_pstate,
    output logic                 dec_bypass,
    output logic [1:0]           dec_n_bin,
    output logic                 dec_step,
    input  logic [BIN_WIDTH-1:0] dec_bin,
    input  logic                 dec_renorm,
    input  logic [2:0]           dec_num_bits,
    output logic                 byte_request,
    input  logic                 byte_ready,
    output logic                 upd_en,
    output logic [1:0]           upd_sel,
    output logic                 bin_valid,
    output logic [BIN_WIDTH-1:0] bins_out,
    output logic [1:0]           bins_cnt,
    output logic                 cmd_done
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_BYTE} state_t;
    state_t state, state_nx;
    logic [7:0]           pstate_q;
    logic                 bypass_q;
    logic [6:0]           num_q, count, rem, count_nx;
    logic signed [3:0]    bn, bn_nx;
    logic [3:0]           neg_bn;
    logic [1:0]           sel_q, n_bin;
    logic [2:0]           add;
    logic [4:0]           idx;
    logic                 done_q, done_nx, accept, need_byte, last;
    logic [BIN_WIDTH-1:0] bin_mask;

    // Step datapath: bins this step, bits-needed update and byte decision.
    always_comb begin
        rem       = num_q - count;
        n_bin     = !bypass_q ? 2'd0 : (rem >= 7'(BIN_WIDTH)) ? 2'(BIN_WIDTH - 1) : 2'(rem - 7'd1);
        add       = bypass_q ? {1'b0, n_bin} + 3'd1 : (dec_renorm ? dec_num_bits : 3'd0);
        idx       = {bn[3], bn} + {2'b00, add};
        // A non-negative idx means the bits-needed counter wrapped: a byte must be fetched.
        need_byte = (state == RUN) && !idx[4];
        bn_nx     = need_byte ? idx[3:0] - 4'd8 : idx[3:0];
        neg_bn    = -bn;
        count_nx  = count + 7'({1'b0, n_bin} + 3'd1);
        last      = count_nx == num_q;
        accept    = (state == IDLE) && cmd_valid && cmd_ready;
        done_nx   = (accept && cmd_num_bins == 7'd0) ||
                    ((state == RUN) && last && !need_byte) ||
                    ((state == WAIT_BYTE) && byte_ready && count == num_q);
        bin_mask  = '0;
        for (int i = 0; i < BIN_WIDTH; i++) bin_mask[i] = i <= int'(n_bin);
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = (accept && cmd_num_bins != 7'd0) ? RUN : IDLE;
            RUN:       state_nx = need_byte ? WAIT_BYTE : last ? IDLE : RUN;
            WAIT_BYTE: state_nx = !byte_ready ? WAIT_BYTE : (count == num_q) ? IDLE : RUN;
            default:   state_nx = IDLE;
        endcase
    end

    // cmd_ready is held low during the cmd_done cycle so a new command is taken the cycle after.
    always_comb begin
        cmd_ready    = (state == IDLE) && !done_q;
        dec_step     = state == RUN;
        dec_n_bin    = (state == RUN) ? n_bin : 2'd0;
        byte_request = state == WAIT_BYTE;
        upd_en       = (state == WAIT_BYTE) && byte_ready;
        upd_sel      = sel_q;
        dec_pstate   = pstate_q;
        dec_bypass   = bypass_q;
        cmd_done     = done_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pstate_q  <= '0;
            bypass_q  <= 1'b0;
            num_q     <= '0;
            count     <= '0;
            bn        <= -4'sd8;
            sel_q     <= '0;
            done_q    <= 1'b0;
            bin_valid <= 1'b0;
            bins_out  <= '0;
            bins_cnt  <= '0;
        end else begin
            if (accept) begin
                pstate_q <= cmd_pstate;
                bypass_q <= cmd_bypass;
                num_q    <= cmd_num_bins;
                count    <= '0;
            end
            if (state == RUN) begin
                count <= count_nx;
                bn    <= bn_nx;
                // Bypass refills go to EP(-bn-1); regular refills go to RE.
                if (need_byte) sel_q <= bypass_q ? neg_bn[1:0] : 2'd0;
                bins_out <= dec_bin & bin_mask;
                bins_cnt <= n_bin;
            end
            bin_valid <= state == RUN;
            done_q    <= done_nx;
        end
    end
endmodule

// File: tb/tb_bin_decode_ctrl.sv
// tb_bin_decode_ctrl: scoreboard bench for bin_decode_ctrl
module tb_bin_decode_ctrl;
    localparam int BW = 3;
    logic          clk = 1'b0, reset = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_bypass = 1'b0;
    logic [7:0]    cmd_pstate = '0, dec_pstate;
    logic [6:0]    cmd_num_bins = '0;
    logic          dec_bypass, dec_step, dec_renorm = 1'b0;
    logic [1:0]    dec_n_bin, upd_sel, bins_cnt;
    logic [BW-1:0] dec_bin = '0, bins_out;
    logic [2:0]    dec_num_bits = '0;
    logic          byte_request, byte_ready = 1'b0, upd_en, bin_valid, cmd_done;

    bin_decode_ctrl #(.BIN_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pstate(cmd_pstate), .cmd_bypass(cmd_bypass), .cmd_num_bins(cmd_num_bins),
        .dec_pstate(dec_pstate), .dec_bypass(dec_bypass), .dec_n_bin(dec_n_bin),
        .dec_step(dec_step), .dec_bin(dec_bin), .dec_renorm(dec_renorm),
        .dec_num_bits(dec_num_bits), .byte_request(byte_request), .byte_ready(byte_ready),
        .upd_en(upd_en), .upd_sel(upd_sel), .bin_valid(bin_valid), .bins_out(bins_out),
        .bins_cnt(bins_cnt), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    typedef struct {int n; int bn;} step_t;
    step_t step_q[$];
    int sel_q[$], bin_q[$], binc_q[$];
    int checks = 0, fails = 0;
    int mbn = -8, stall_len = 0, wait_cnt = 0, upd_cnt = 0, stall_cnt = 0;
    int bn_chk_pending = 0, bn_chk_val = 0;
    logic [7:0] cur_pstate = '0;
    logic cur_bypass = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Decoder bins and byte reader: bytes arrive after stall_len waiting cycles,
    // and byte_ready toggles randomly when nothing is requested.
    always @(posedge clk) begin
        #1;
        dec_bin = BW'($urandom_range(0, (1 << BW) - 1));
        if (byte_request) begin
            byte_ready = wait_cnt >= stall_len;
            wait_cnt++;
        end else begin
            byte_ready = 1'($urandom_range(0, 1));
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (bn_chk_pending != 0) begin
                check("bn", dut.bn, bn_chk_val);
                bn_chk_pending = 0;
            end
            if (byte_request) begin
                check("upd_en", upd_en, byte_ready);
                check("no_step_in_wait", dec_step, 0);
                if (!byte_ready) stall_cnt++;
            end else begin
                check("upd_en_idle", upd_en, 0);
            end
            if (upd_en) begin
                upd_cnt++;
                check("upd_expected", sel_q.size() > 0, 1);
                if (sel_q.size() > 0) check("upd_sel", upd_sel, sel_q.pop_front());
            end
            if (dec_step) begin
                check("step_expected", step_q.size() > 0, 1);
                if (step_q.size() > 0) begin
                    step_t s;
                    s = step_q.pop_front();
                    check("dec_n_bin", dec_n_bin, s.n);
                    check("dec_pstate", dec_pstate, cur_pstate);
                    check("dec_bypass", dec_bypass, cur_bypass);
                    bin_q.push_back(int'(dec_bin) & ((1 << (s.n + 1)) - 1));
                    binc_q.push_back(s.n);
                    bn_chk_pending = 1;
                    bn_chk_val = s.bn;
                end
            end
            if (bin_valid) begin
                check("bin_expected", bin_q.size() > 0, 1);
                if (bin_q.size() > 0) begin
                    check("bins_out", bins_out, bin_q.pop_front());
                    check("bins_cnt", bins_cnt, binc_q.pop_front());
                end
            end
        end
    end

    // Predicts the step sequence and byte targets, then drives the command.
    task automatic issue(input int ps, input bit bp, input int nb, input bit rn, input int nbits,
                         input int stall, output int nbyte);
        int t, cnt, n, idx;
        step_t s;
        t = 0;
        while (!cmd_ready && t < 50) begin
            tick();
            t++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cnt = 0;
        nbyte = 0;
        while (cnt < nb) begin
            if (bp) begin
                n = (nb - cnt > BW) ? BW - 1 : nb - cnt - 1;
                idx = mbn + n + 1;
                if (idx >= 0) begin
                    sel_q.push_back(-mbn);
                    mbn = idx - 8;
                    nbyte++;
                end else mbn = idx;
                cnt += n + 1;
            end else begin
                n = 0;
                if (rn) begin
                    idx = mbn + nbits;
                    if (idx >= 0) begin
                        sel_q.push_back(0);
                        mbn = idx - 8;
                        nbyte++;
                    end else mbn = idx;
                end
                cnt++;
            end
            s.n = n;
            s.bn = mbn;
            step_q.push_back(s);
        end
        cur_pstate = 8'(ps);
        cur_bypass = bp;
        dec_renorm = rn;
        dec_num_bits = 3'(nbits);
        stall_len = stall;
        upd_cnt = 0;
        stall_cnt = 0;
        cmd_pstate = 8'(ps);
        cmd_bypass = bp;
        cmd_num_bins = 7'(nb);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_pstate = 8'($urandom);
        cmd_bypass = ~bp;
        cmd_num_bins = 7'($urandom);
    endtask

    task automatic finish_cmd(input int exp_upd, input int exp_stall);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("cmd_done_seen", cmd_done, 1);
        check("cmd_ready_during_done", cmd_ready, 0);
        @(negedge clk);
        check("cmd_done_pulse", cmd_done, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
        check("steps_left", step_q.size(), 0);
        check("bins_left", bin_q.size(), 0);
        check("upd_count", upd_cnt, exp_upd);
        check("stall_count", stall_cnt, exp_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nbyte, t, nb, st;
        bit bp, rn;
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_dec_step", dec_step, 0);
        check("rst_byte_request", byte_request, 0);
        check("rst_upd_en", upd_en, 0);
        check("rst_upd_sel", upd_sel, 0);
        check("rst_bin_valid", bin_valid, 0);
        check("rst_bins_out", bins_out, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_dec_pstate", dec_pstate, 0);
        check("rst_bn", dut.bn, -8);
        @(posedge clk);
        #1;

        issue(8'h11, 1, 7, 0, 0, 0, nbyte);
        finish_cmd(0, 0);
        check("bn_after_bypass7", dut.bn, -1);

        issue(8'h22, 1, 4, 0, 0, 0, nbyte);
        finish_cmd(1, 0);
        check("bn_after_bypass4", dut.bn, -5);

        issue(8'h33, 0, 3, 1, 3, 5, nbyte);
        finish_cmd(1, 5);
        check("bn_after_regular3", dut.bn, -4);

        issue(8'h44, 1, 0, 0, 0, 0, nbyte);
        finish_cmd(0, 0);

        issue(8'h55, 0, 1, 1, 7, 100, nbyte);
        t = 0;
        while (!byte_request && t < 20) begin
            tick();
            t++;
        end
        check("wait_byte_reached", byte_request, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_byte_request", byte_request, 0);
        check("rst_wait_bn", dut.bn, -8);
        check("rst_wait_state", dut.state, 0);
        check("rst_wait_cmd_ready", cmd_ready, 1);
        step_q.delete();
        sel_q.delete();
        bin_q.delete();
        binc_q.delete();
        bn_chk_pending = 0;
        mbn = -8;
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) begin
            bp = 1'($urandom_range(0, 1));
            rn = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 20);
            st = $urandom_range(0, 3);
            issue($urandom_range(0, 255), bp, nb, rn, $urandom_range(0, 7), st, nbyte);
            finish_cmd(nbyte, nbyte * st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bin_decode_ctrl.md
Name: bin_decode_ctrl

Overview:
Hardware sequencer for the arithmetic Decoder datapath. It accepts bin-group commands (pState, bypass flag, bin count) and steps the Decoder one bin per regular step, or up to BIN_WIDTH bins per bypass step. It tracks the bits-needed counter and requests bitstream bytes from the byte reader. It tells the datapath which m_value path (RE, EP0..EP2) absorbs each fetched byte, and emits the decoded bins.

Parameters:
BIN_WIDTH, 3, maximum bins decoded per bypass step (1..3); also the width of the bin buses.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_pstate  in  8  context state for the command.
cmd_bypass  in  1  1 = bypass bins, 0 = regular bins.
cmd_num_bins  in  7  number of bins in the command (0..127).
dec_pstate  out  8  latched pState driven to the Decoder.
dec_bypass  out  1  latched bypass flag driven to the Decoder.
dec_n_bin  out  2  bins in this step minus 1.
dec_step  out  1  Decoder consumes/advances this cycle.
dec_bin  in  BIN_WIDTH  combinational bins from the Decoder.
dec_renorm  in  1  regular bin required renormalisation.
dec_num_bits  in  3  renorm shift amount for a regular bin.
byte_request  out  1  byte fetch request, held until the byte is accepted.
byte_ready  in  1  byte available from the reader.
upd_en  out  1  datapath adds the byte into the selected m_value path.
upd_sel  out  2  target path: 0 = RE (shifted by numBits), 1 = EP0, 2 = EP1, 3 = EP2.
bin_valid  out  1  bins_out is valid.
bins_out  out  BIN_WIDTH  decoded bins, LSB = first bin; unused bits are 0.
bins_cnt  out  2  valid bins in bins_out minus 1.
cmd_done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state = IDLE; bn (signed 4-bit bits-needed) = -8; count = 0.
  - All outputs 0 except cmd_ready = 1.
  - Reset overrides any state, including mid-WAIT_BYTE.
- States: IDLE, RUN, WAIT_BYTE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch pstate, bypass and num_bins; count = 0.
  - If num_bins = 0: pulse cmd_done next cycle and stay in IDLE.
  - Otherwise go to RUN. cmd_ready drops the cycle after acceptance.
- RUN: dec_step = 1 every cycle.
  - rem = num_bins - count.
  - Bypass step:
    - dec_n_bin = min(rem, BIN_WIDTH) - 1.
    - idx = bn + dec_n_bin + 1.
    - If idx >= 0: bn <= idx - 8, upd_sel <= -bn_old (always 1..3), go to WAIT_BYTE.
    - Else bn <= idx.
    - count += dec_n_bin + 1.
  - Regular step:
    - dec_n_bin = 0; count += 1.
    - If dec_renorm = 1: idx = bn + dec_num_bits. If idx >= 0: bn <= idx - 8, upd_sel <= 0, go to WAIT_BYTE; else bn <= idx.
    - If dec_renorm = 0: bn unchanged.
- Bin output:
  - Each dec_step registers dec_bin, masked to dec_n_bin+1 bits, into bins_out; bins_cnt = dec_n_bin.
  - bin_valid = 1 the cycle after the step (1-cycle latency). There is no backpressure.
- Byte handshake:
  - byte_request rises on entry to WAIT_BYTE and is held until byte_ready = 1.
  - In that cycle upd_en = 1 with upd_sel stable, then byte_request drops.
  - byte_ready while byte_request = 0 is ignored.
  - No dec_step occurs in WAIT_BYTE.
- Completion:
  - When count reaches num_bins and no byte is pending, pulse cmd_done.
  - If the last step needed a byte, cmd_done pulses the cycle after the byte is accepted.
  - The controller then returns to IDLE, with cmd_ready = 1 the following cycle.
- Persistence and width rules:
  - bn persists across commands; only reset reinitialises it.
  - count is 7-bit and never exceeds num_bins.
  - bn always stays in -8..-1 after each update.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> bn=-8, cmd_ready=1, all other outputs 0, no dec_step.
2. Bypass command, 7 bins, from bn=-8 -> three steps with dec_n_bin 2, 2, 0; bn -5, -2, -1; no byte_request; cmd_done after the 3rd step; bins_cnt 2, 2, 0.
3. Follow-up bypass command, 4 bins (bn=-1) -> step with n_bin=2 gives idx=2: byte_request, upd_sel=1, bn=-6; after byte_ready, step with n_bin=0 gives bn=-5; then cmd_done.
4. Regular command, 3 bins, with dec_renorm=1 and dec_num_bits=3, starting from bn=-5 -> bn goes to -2, then request byte with upd_sel=0 and bn=-7, then bn=-4; exactly one upd_en.
5. Byte stall: in WAIT_BYTE, hold byte_ready=0 for 5 cycles -> byte_request stays high, dec_step=0 and count frozen; the 6th cycle byte_ready=1 gives a single upd_en pulse.
6. Corner cases: cmd_num_bins=0 -> cmd_done pulse with no dec_step. Reset asserted during WAIT_BYTE -> next cycle byte_request=0, bn=-8, state IDLE.
